// File: rtl/counter_load_arbiter.sv
// Arbitrates the Unix-seconds counter's single parallel-load port between the UI set path and time-sync.
// Optional round-robin tie breaking is enabled with `define COUNTER_LOAD_ARB_RR_EN.
module counter_load_arbiter #(
    parameter int N           = 64,
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_PRIO   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ui_req,
    input  logic [N-1:0] ui_value,
    output logic         ui_ack,
    input  logic         sync_req,
    input  logic [N-1:0] sync_value,
    output logic         sync_ack,
    output logic         load_n,
    output logic [N-1:0] set_value,
    output logic         busy,
    output logic [1:0]   last_src,
    output logic [7:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic       ui_armed;
    logic       sync_armed;
    logic       ui_elig;
    logic       sync_elig;
    logic       pick_sync;
    logic       win_sync;
    logic [7:0] hold_cnt;

    // A requester must drop its req for a cycle before it can be granted again.
    assign ui_elig   = ui_req & ui_armed;
    assign sync_elig = sync_req & sync_armed;

    always_comb begin
        pick_sync = sync_elig;
        if (ui_elig && sync_elig) begin
`ifdef COUNTER_LOAD_ARB_RR_EN
            case (last_src)
                2'b01:   pick_sync = 1'b1;
                2'b10:   pick_sync = 1'b0;
                default: pick_sync = (SYNC_PRIO != 0);
            endcase
`else
            pick_sync = (SYNC_PRIO != 0);
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ui_elig || sync_elig) state_nx = LOAD;
            LOAD:    state_nx = ACK;
            ACK:     state_nx = HOLD;
            HOLD:    if (hold_cnt == 8'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_n     <= 1'b1;
            ui_ack     <= 1'b0;
            sync_ack   <= 1'b0;
            set_value  <= '0;
            win_sync   <= 1'b0;
            last_src   <= 2'b00;
            load_count <= 8'd0;
            hold_cnt   <= 8'd0;
        end else begin
            load_n   <= 1'b1;
            ui_ack   <= 1'b0;
            sync_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (ui_elig || sync_elig) begin
                        set_value <= pick_sync ? sync_value : ui_value;
                        win_sync  <= pick_sync;
                        load_n    <= 1'b0;
                    end
                end
                LOAD: begin
                    ui_ack   <= ~win_sync;
                    sync_ack <= win_sync;
                    last_src <= win_sync ? 2'b10 : 2'b01;
                    if (load_count != 8'hFF) load_count <= load_count + 8'd1;
                end
                ACK: begin
                    hold_cnt <= HOLD_M1;
                end
                HOLD: begin
                    if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
                end
                default: begin
                    hold_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_armed   <= 1'b1;
            sync_armed <= 1'b1;
        end else begin
            if (!ui_req) ui_armed <= 1'b1;
            else if (ui_ack) ui_armed <= 1'b0;
            if (!sync_req) sync_armed <= 1'b1;
            else if (sync_ack) sync_armed <= 1'b0;
        end
    end

endmodule
